// File: rtl/alu_req_scheduler.sv
// ---------------------------------------------------------------------------
// alu_req_scheduler
//   Shares one combinational ALU between two requesters. A round-robin
//   arbiter picks a winner in IDLE, the winner's operands are registered onto
//   the ALU inputs, the result is captured after EXEC_CYCLES cycles and held
//   on a single response port until the consumer takes it.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   reqN_valid/ready        request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b          operands A/B for requester N
//   reqN_sel                op select for requester N
//   alu_a, alu_b, alu_sel   registered operand/select drive to the shared ALU
//   alu_result              ALU result (DATA_W+1 bits, carry included)
//   rsp_valid/ready         response handshake
//   rsp_id                  requester that owns the response
//   rsp_data                captured ALU result, unmodified
//   dbg_state               current FSM state (0 IDLE, 1 EXEC, 2 RESP)
//   grant_cnt0/1            saturating accept counters, only when the
//                           ALU_SCHED_STATS_EN macro is defined
//
// Handshake semantics (all ports): a transfer happens on a rising edge where
// valid and ready are both high. A requester keeps valid high with stable
// payload until it sees ready; reqN_ready is combinational and only high in
// IDLE for the granted requester. rsp_valid, once high, stays high with
// stable rsp_id/rsp_data until the edge where rsp_ready is also high.
// ---------------------------------------------------------------------------
module alu_req_scheduler #(
  parameter int DATA_W      = 8,
  parameter int SEL_W       = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W:0]   alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W:0]   rsp_data,
`ifdef ALU_SCHED_STATS_EN
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] C_CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_cnt;
  logic                r_last_grant;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [SEL_W-1:0]    r_alu_sel;
  logic                r_rsp_valid;
  logic                r_rsp_id;
  logic [DATA_W:0]     r_rsp_data;

  logic                w_any_valid;
  logic                w_grant;
  logic                w_accept;

  // On a tie the requester that did not win last time goes first. r_last_grant
  // resets to 1 so requester 0 wins the first tie.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) w_grant = ~r_last_grant;
    else if (req1_valid)          w_grant = 1'b1;
  end

  assign w_any_valid = req0_valid | req1_valid;
  assign w_accept    = (r_state == IDLE) && w_any_valid;
  assign req0_ready  = w_accept && !w_grant;
  assign req1_ready  = w_accept &&  w_grant;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = EXEC;
      EXEC:    if (r_cnt == 4'd0) w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_sel    <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alu_a      <= w_grant ? req1_a   : req0_a;
            r_alu_b      <= w_grant ? req1_b   : req0_b;
            r_alu_sel    <= w_grant ? req1_sel : req0_sel;
            r_rsp_id     <= w_grant;
            r_last_grant <= w_grant;
            r_cnt        <= C_CNT_LOAD;
          end
        end
        EXEC: begin
          if (r_cnt == 4'd0) begin
            r_rsp_data  <= alu_result;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;
  assign dbg_state = r_state;

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt0 <= 16'd0;
      r_grant_cnt1 <= 16'd0;
    end else if (w_accept) begin
      if (!w_grant && r_grant_cnt0 != 16'hFFFF) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if ( w_grant && r_grant_cnt1 != 16'hFFFF) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_alu_req_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_req_scheduler
//   Directed bench for alu_req_scheduler. u_dut (EXEC_CYCLES=1) talks to a
//   small behavioural ALU; u_dut3 (EXEC_CYCLES=3) gets its alu_result driven
//   cycle by cycle so the capture point can be pinned down. Expected
//   responses are queued when a request is accepted and compared when the
//   response handshake happens.
// ---------------------------------------------------------------------------
module tb_alu_req_scheduler;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_sel, req1_sel;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [8:0] alu_result;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [8:0] rsp_data;
  logic [1:0] dbg_state;

  logic       t3_req0_valid, t3_req0_ready, t3_req1_ready;
  logic [7:0] t3_alu_a, t3_alu_b;
  logic [3:0] t3_alu_sel;
  logic [8:0] t3_alu_result;
  logic       t3_rsp_valid, t3_rsp_ready, t3_rsp_id;
  logic [8:0] t3_rsp_data;
  logic [1:0] t3_dbg_state;

`ifdef ALU_SCHED_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1, t3_gc0, t3_gc1;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [9:0] exp_q[$];
  int         tb_cnt0 = 0;
  int         tb_cnt1 = 0;

  // ---------------- clock / reset -----------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: 0 add, 1 subtract, 2 and, others xor; 9-bit result.
  function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] s);
    case (s)
      4'h0:    alu_f = {1'b0, a} + {1'b0, b};
      4'h1:    alu_f = {1'b0, a} - {1'b0, b};
      4'h2:    alu_f = {1'b0, a & b};
      default: alu_f = {1'b0, a ^ b};
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_sel);

  alu_req_scheduler #(.DATA_W(8), .SEL_W(4), .EXEC_CYCLES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
`ifdef ALU_SCHED_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .dbg_state(dbg_state)
  );

  alu_req_scheduler #(.DATA_W(8), .SEL_W(4), .EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(t3_req0_valid), .req0_ready(t3_req0_ready),
    .req0_a(8'h10), .req0_b(8'h20), .req0_sel(4'h0),
    .req1_valid(1'b0), .req1_ready(t3_req1_ready),
    .req1_a(8'h00), .req1_b(8'h00), .req1_sel(4'h0),
    .alu_a(t3_alu_a), .alu_b(t3_alu_b), .alu_sel(t3_alu_sel), .alu_result(t3_alu_result),
    .rsp_valid(t3_rsp_valid), .rsp_ready(t3_rsp_ready), .rsp_id(t3_rsp_id),
    .rsp_data(t3_rsp_data),
`ifdef ALU_SCHED_STATS_EN
    .grant_cnt0(t3_gc0), .grant_cnt1(t3_gc1),
`endif
    .dbg_state(t3_dbg_state)
  );

  // ---------------- driver / checker tasks --------------------------------
  // Inputs are driven 2 time units after a rising edge; registered outputs
  // are sampled there too, combinational ones 1 unit after driving.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op on requester id, wait (bounded) for ready, queue the
  // expected response, complete the accepting edge and drop valid.
  task automatic issue(input string tag, input bit id, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] sel);
    int n;
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 50) begin
      tick(); #1; n++;
    end
    chk({tag, "_ready"}, {31'd0, id ? req1_ready : req0_ready}, 32'd1);
    exp_q.push_back({id, alu_f(a, b, sel)});
    if (id) tb_cnt1++; else tb_cnt0++;
    tick();
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, compare with the queue head, handshake it.
  task automatic get_rsp(input string tag);
    int n;
    logic [9:0] e;
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick(); n++;
    end
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'bx;
    chk({tag, "_id"},   {31'd0, rsp_id},   {31'd0, e[9]});
    chk({tag, "_data"}, {23'd0, rsp_data}, {23'd0, e[8:0]});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_clr"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  // ---------------- directed sequence -------------------------------------
  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
    rsp_ready = 1'b0;
    t3_req0_valid = 1'b0; t3_rsp_ready = 1'b0; t3_alu_result = 9'h111;

    // Reset, then idle with nothing valid.
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_r0", {31'd0, req0_ready}, 32'd0);
      chk("idle_r1", {31'd0, req1_ready}, 32'd0);
      chk("idle_state", {30'd0, dbg_state}, 32'd0);
      tick();
    end
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);

    // Single op: F0 + 0F, result one edge after acceptance.
    req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h0F; req0_sel = 4'h0;
    #1;
    chk("single_r0_first", {31'd0, req0_ready}, 32'd1);
    chk("single_r1_low", {31'd0, req1_ready}, 32'd0);
    issue("single", 1'b0, 8'hF0, 8'h0F, 4'h0);
    chk("single_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("single_alu_a", {24'd0, alu_a}, 32'h0F0);
    chk("single_alu_b", {24'd0, alu_b}, 32'h00F);
    chk("single_r0_exec", {31'd0, req0_ready}, 32'd0);
    tick();
    chk("single_lat_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_lat_data", {23'd0, rsp_data}, 32'h0FF);
    get_rsp("single");

    // Subtract on requester 1 (borrow visible in bit 8).
    issue("sub", 1'b1, 8'h05, 8'h07, 4'h1);
    get_rsp("sub");

    // Reset mid-operation: op sitting in RESP is discarded immediately.
    issue("midrst", 1'b1, 8'h12, 8'h34, 4'h3);
    tick();
    chk("midrst_pre_valid", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_data", {23'd0, rsp_data}, 32'd0);
    chk("midrst_id", {31'd0, rsp_id}, 32'd0);
    chk("midrst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("midrst_alu_sel", {28'd0, alu_sel}, 32'd0);
    chk("midrst_state", {30'd0, dbg_state}, 32'd0);
    exp_q.delete();
    tb_cnt0 = 0; tb_cnt1 = 0;

    // Tie from reset: requester 0 first, then requester 1.
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h00; req1_sel = 4'h0;
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'hFF; req0_sel = 4'h0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("tie_r0", {31'd0, req0_ready}, 32'd1);
    chk("tie_r1", {31'd0, req1_ready}, 32'd0);
    issue("tie_a", 1'b0, 8'hFF, 8'hFF, 4'h0);
    #1;
    chk("tie_r1_blocked", {31'd0, req1_ready}, 32'd0);
    get_rsp("tie_a");
    issue("tie_b", 1'b1, 8'hFF, 8'h00, 4'h0);
    get_rsp("tie_b");

    // Requester 0 alone, then a simultaneous pair goes to requester 1 first.
    issue("rr_solo", 1'b0, 8'h3C, 8'h0F, 4'h2);
    get_rsp("rr_solo");
    req0_valid = 1'b1; req0_a = 8'hAA; req0_b = 8'h55; req0_sel = 4'h3;
    req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h80; req1_sel = 4'h0;
    #1;
    chk("rr_pair_r1", {31'd0, req1_ready}, 32'd1);
    chk("rr_pair_r0", {31'd0, req0_ready}, 32'd0);
    issue("rr_pair1", 1'b1, 8'h80, 8'h80, 4'h0);
    get_rsp("rr_pair1");
    issue("rr_pair0", 1'b0, 8'hAA, 8'h55, 4'h3);
    get_rsp("rr_pair0");

    // Backpressure: response held 5 cycles while requester 1 waits.
    issue("bp_a", 1'b0, 8'h21, 8'h43, 4'h0);
    req1_valid = 1'b1; req1_a = 8'h09; req1_b = 8'h03; req1_sel = 4'h1;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", {23'd0, rsp_data}, 32'h064);
      chk("bp_id", {31'd0, rsp_id}, 32'd0);
      chk("bp_r1", {31'd0, req1_ready}, 32'd0);
      tick();
    end
    get_rsp("bp_a");
    #1;
    chk("bp_r1_first_idle", {31'd0, req1_ready}, 32'd1);
    issue("bp_b", 1'b1, 8'h09, 8'h03, 4'h1);
    get_rsp("bp_b");

    // Settle time on the EXEC_CYCLES=3 instance.
    t3_req0_valid = 1'b1;
    #1;
    chk("t3_ready", {31'd0, t3_req0_ready}, 32'd1);
    tick();
    t3_req0_valid = 1'b0;
    chk("t3_alu_a", {24'd0, t3_alu_a}, 32'h010);
    t3_alu_result = 9'h111;
    tick();
    chk("t3_edge1", {31'd0, t3_rsp_valid}, 32'd0);
    t3_alu_result = 9'h122;
    tick();
    chk("t3_edge2", {31'd0, t3_rsp_valid}, 32'd0);
    t3_alu_result = 9'h133;
    tick();
    t3_alu_result = 9'h144;
    chk("t3_edge3_valid", {31'd0, t3_rsp_valid}, 32'd1);
    chk("t3_edge3_data", {23'd0, t3_rsp_data}, 32'h133);
    chk("t3_edge3_id", {31'd0, t3_rsp_id}, 32'd0);
    t3_rsp_ready = 1'b1;
    tick();
    t3_rsp_ready = 1'b0;
    chk("t3_clr", {31'd0, t3_rsp_valid}, 32'd0);

`ifdef ALU_SCHED_STATS_EN
    chk("stats_cnt0", {16'd0, grant_cnt0}, tb_cnt0);
    chk("stats_cnt1", {16'd0, grant_cnt1}, tb_cnt1);
    rst_n = 1'b0;
    #1;
    chk("stats_rst0", {16'd0, grant_cnt0}, 32'd0);
    chk("stats_rst1", {16'd0, grant_cnt1}, 32'd0);
    tick();
    rst_n = 1'b1;
`endif

    chk("queue_drained", exp_q.size(), 32'd0);

    // ---------------- report ----------------------------------------------
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
